xi_port_arbiter: RTL and testbench
==================================

# xi_port_arbiter

Shares one 64-bit AXI4 read master port to the X-vector memory among `NUM_REQ` SpMV lanes, each issuing single-beat Xi reads.
- Round-robin arbitration over lane requests; one AR per grant.
- In-order tracking of outstanding reads in a grant-order FIFO.
- Each R beat routed back to the lane that issued it.
- Sits between the per-lane Xi reader front ends and the shared Xi AXI interconnect port; bounds outstanding reads to `MAX_OUTSTANDING`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting lanes (2..8)
- `MAX_OUTSTANDING`, 8, max AR issued without final R beat (power of two)
- `XVAL_BASE_ADDR`, 32'h40000000, base added to every lane offset
- `ADDR_W`, 48, AXI address width
- `DATA_W`, 64, AXI data width

Ports:
- `clk` in 1: single clock domain
- `rst` in 1: reset, synchronous, active-high
- `req_valid` in NUM_REQ: lane i has an Xi read pending
- `req_ready` out NUM_REQ: one-hot; lane i request accepted this cycle
- `req_offset` in NUM_REQ*32: lane i byte offset, packed lane 0 in [31:0]
- `rsp_valid` out NUM_REQ: one-hot; data for lane i on `rsp_data`
- `rsp_ready` in NUM_REQ: lane i can take data
- `rsp_data` out DATA_W: shared response bus
- `rsp_err` out 1: `rresp != 0` on the current beat
- `protocol_err` out 1: sticky; R beat arrived with nothing outstanding
- `m_axi_arid` out 1, `m_axi_araddr` out ADDR_W, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arlock` out 1, `m_axi_arcache` out 4, `m_axi_arprot` out 3, `m_axi_arqos` out 4, `m_axi_arvalid` out 1, `m_axi_arready` in 1
- `m_axi_rid` in 1, `m_axi_rdata` in DATA_W, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1

## Operation
- Constant AR fields:
  - `arid`=0, `arlen`=0, `arsize`=3, `arburst`=INCR, `arlock`=0, `arcache`=4'b0011, `arprot`=0, `arqos`=0.
- Address:
  - `araddr` = `XVAL_BASE_ADDR` + zero-extended `req_offset[i]`, with bits [2:0] forced to 0.
- AR slot: one register holding `arvalid`, `araddr` and the lane index.
  - The slot is free when `!arvalid || arready`.
  - Address and lane index stay stable while `arvalid && !arready`.
- Grant conditions (all required): slot free, `outstanding + arvalid < MAX_OUTSTANDING`, FIFO not full, any `req_valid`.
- Grant selection: round-robin starting at `rr_ptr`, choosing the first lane with `req_valid`.
  - `req_ready[winner]`=1; the slot loads `arvalid`=1.
  - `rr_ptr` ← winner+1, mod `NUM_REQ`.
- On AR handshake: push the lane index into the grant-order FIFO; `outstanding`+1.
- R routing while the FIFO is non-empty (head = lane h):
  - `rsp_valid[h]` = `rvalid`; all other lanes 0.
  - `rready` = `rsp_ready[h]`.
  - `rsp_data` = `rdata`; `rsp_err` = `rvalid && rresp != 0`.
- On R handshake with `rlast`: pop the FIFO; `outstanding`−1.
- AR handshake and R pop in the same cycle: `outstanding` unchanged; FIFO push and pop both occur.
- FIFO empty while `rvalid`=1:
  - `rready`=1 and the beat is dropped.
  - All `rsp_valid`=0; `protocol_err` ← 1 until reset.
- Invariant: `outstanding` equals the FIFO occupancy, in range 0..`MAX_OUTSTANDING`.

## Timing
- Reset values:
  - `arvalid`=0, `araddr`=0, `rr_ptr`=0, `outstanding`=0, FIFO empty.
  - `protocol_err`=0, `req_ready`=0, `rsp_valid`=0, `rready`=0.
- Request accepted in cycle N → `arvalid`=1 with the new address from N+1.
- Back-to-back: a grant is allowed in the same cycle as `arready`, giving 1 AR/cycle sustained.
- `req_ready` is combinational from `req_valid`, slot state and counters. No combinational path from `arready` to `req_ready` beyond the slot-free term.
- Response path is combinational pass-through with 0 cycles latency; lane backpressure propagates directly to `rready`.
- At `outstanding`=`MAX_OUTSTANDING`: no grant until a pop is registered. The first grant is permitted in the cycle after the pop.
- `rst` mid-operation: all state cleared next edge and in-flight reads forgotten. `rst` must only be asserted together with the AXI slave reset.

## Structure
- Package `xi_arb_pkg`:
  - AR constants `AXI_ARSIZE_8B`=3, `AXI_BURST_INCR`=2'b01, `AXI_ARCACHE_DEF`=4'b0011.
  - Lane-index width function `clog2`.
- Sub-module `grant_order_fifo`:
  - Synchronous FIFO, width clog2(NUM_REQ), depth `MAX_OUTSTANDING`.
  - Ports: push, pop, full, empty, head; simultaneous push/pop at full is legal.
- Top level holds the round-robin arbiter, AR slot, outstanding counter and R demux.

## Test plan
- Single lane 2, `req_offset`=0x1C, `arready`=1 → next cycle `araddr`=0x40000018, `arlen`=0. Then R `rdata`=0xAA with `rlast` → `rsp_valid`=4'b0100, `rsp_data`=0xAA.
- All 4 lanes `req_valid` held, `arready`=1, no R → grants in order 0,1,2,3,0,1,2,3 over 8 consecutive cycles. Cycle 9: `req_ready`=0 (limit 8 reached).
- `arready` low 5 cycles with lane 1 requesting → `arvalid` and `araddr` stable for all 5 cycles; no further `req_ready` until the handshake.
- Issue lanes 3,0,2 then return 3 beats with `rsp_ready` of lane 0 low for 4 cycles → beat 2 stalls (`rready`=0) and is delivered to lane 0 afterwards. Delivery order is lanes 3,0,2.
- R beat with FIFO empty → `rready`=1, `protocol_err`=1 stays high. `rst` pulse clears it.
- Beat with `rresp`=2'b10 → `rsp_err`=1 in that cycle only. `rst` during 3 outstanding → `outstanding`=0, `arvalid`=0 the next cycle.

Source files
------------

// File: rtl/xi_arb_pkg.sv
// Shared constants and helpers for the Xi read-port arbiter.
package xi_arb_pkg;

    localparam logic [2:0] AXI_ARSIZE_8B   = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_ARCACHE_DEF = 4'b0011;

    // Width needed to hold an index in 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/grant_order_fifo.sv
// Remembers which lane owns each outstanding read, oldest first.
module grant_order_fifo
    import xi_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full   = (count_q == (PW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Pointer and occupancy bookkeeping; push and pop may coincide even when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= (wrPtr_q == PW'(DEPTH-1)) ? '0 : wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= (rdPtr_q == PW'(DEPTH-1)) ? '0 : rdPtr_q + PW'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    // Storage array needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/xi_port_arbiter.sv
// Round-robin sharing of one single-beat AXI4 read port among several SpMV lanes.
module xi_port_arbiter
    import xi_arb_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [31:0] XVAL_BASE_ADDR  = 32'h40000000,
    parameter int          ADDR_W          = 48,
    parameter int          DATA_W          = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_offset,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  protocol_err,
    output logic                  m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int LW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_OUTSTANDING) + 1;

    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LW-1:0]     arlane_q, arlane_d;
    logic [LW-1:0]     rrPtr_q, rrPtr_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic              protocolErr_q, protocolErr_d;

    logic              winnerFound;
    logic [LW-1:0]     winner;
    logic [LW-1:0]     probe;
    logic [31:0]       winOffset;
    logic [ADDR_W-1:0] sumAddr;
    logic [CW:0]       inFlight;
    logic              slotFree;
    logic              budgetOk;
    logic              grant;
    logic              arHandshake;
    logic              rPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [LW-1:0]     headLane;
    logic              unusedRid;

    assign unusedRid = m_axi_rid;

    assign m_axi_arid    = 1'b0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_ARSIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_ARCACHE_DEF;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign protocol_err  = protocolErr_q;

    // Pick the first requesting lane at or after the round-robin pointer.
    always_comb begin
        winnerFound = 1'b0;
        winner      = '0;
        probe       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = LW'((int'(rrPtr_q) + k) % NUM_REQ);
            if (!winnerFound && req_valid[probe]) begin
                winnerFound = 1'b1;
                winner      = probe;
            end
        end
    end

    // Fetch the winning lane's offset and form the 8-byte-aligned address.
    always_comb begin
        winOffset = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == LW'(i)) begin
                winOffset = req_offset[i*32 +: 32];
            end
        end
        sumAddr = ADDR_W'(XVAL_BASE_ADDR) + ADDR_W'(winOffset);
    end

    assign slotFree    = !arvalid_q || m_axi_arready;
    assign inFlight    = {1'b0, outstanding_q} + (CW+1)'(arvalid_q);
    assign budgetOk    = inFlight < (CW+1)'(MAX_OUTSTANDING);
    assign grant       = slotFree && budgetOk && !fifoFull && winnerFound;
    assign arHandshake = arvalid_q && m_axi_arready;

    // One-hot acceptance strobe for the lane that wins this cycle.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Steer the R channel to the oldest outstanding lane, or swallow stray beats.
    always_comb begin
        rsp_valid    = '0;
        rsp_data     = m_axi_rdata;
        rsp_err      = 1'b0;
        m_axi_rready = 1'b0;
        if (!fifoEmpty) begin
            rsp_valid[headLane] = m_axi_rvalid;
            m_axi_rready        = rsp_ready[headLane];
            rsp_err             = m_axi_rvalid && (m_axi_rresp != 2'b00);
        end else begin
            m_axi_rready = m_axi_rvalid;
        end
    end

    assign rPop = !fifoEmpty && m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Next-state for the AR slot, arbitration pointer, counter and error flag.
    always_comb begin
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlane_d      = arlane_q;
        rrPtr_d       = rrPtr_q;
        outstanding_d = outstanding_q;
        protocolErr_d = protocolErr_q;
        if (grant) begin
            arvalid_d = 1'b1;
            araddr_d  = {sumAddr[ADDR_W-1:3], 3'b000};
            arlane_d  = winner;
            rrPtr_d   = (winner == LW'(NUM_REQ-1)) ? '0 : winner + LW'(1);
        end else if (m_axi_arready) begin
            arvalid_d = 1'b0;
        end
        if (arHandshake && !rPop) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (rPop && !arHandshake) begin
            outstanding_d = outstanding_q - CW'(1);
        end
        if (fifoEmpty && m_axi_rvalid) begin
            protocolErr_d = 1'b1;
        end
    end

    // Register all arbiter state; reset forgets every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlane_q      <= '0;
            rrPtr_q       <= '0;
            outstanding_q <= '0;
            protocolErr_q <= 1'b0;
        end else begin
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlane_q      <= arlane_d;
            rrPtr_q       <= rrPtr_d;
            outstanding_q <= outstanding_d;
            protocolErr_q <= protocolErr_d;
        end
    end

    grant_order_fifo #(
        .WIDTH (LW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order (
        .clk   (clk),
        .rst   (rst),
        .push  (arHandshake),
        .pop   (rPop),
        .wdata (arlane_q),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .head  (headLane)
    );

endmodule

// File: tb/tb_xi_port_arbiter.sv
// Randomized and directed checking of xi_port_arbiter against a queue-based model.
module tb_xi_port_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_offset;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    logic          protocol_err;
    logic          m_axi_arid;
    logic [47:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic          m_axi_rid;
    logic [63:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: lanes awaiting data in issue order, plus the pending AR.
    int          mQ[$];
    bit          mArv;
    logic [47:0] mAddr;
    int          mLane;
    int          mRr;
    bit          mProt;

    logic [N*32-1:0] tbOff;
    logic [63:0]     tbRdata;
    logic [3:0]      tp2Exp [9];

    always #5 clk = ~clk;

    xi_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_offset    (req_offset),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .protocol_err  (protocol_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared = compared + 1;
        if (observed !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [47:0] laneAddr(input int lane);
        logic [N*32-1:0] shifted;
        logic [63:0]     sum;
        shifted  = tbOff >> (32 * lane);
        sum      = 64'h0000_0000_4000_0000 + {32'h0, shifted[31:0]};
        sum[2:0] = 3'b000;
        return sum[47:0];
    endfunction

    // One clock of stimulus: drive at negedge, compare against the model, advance the model.
    task automatic applyStimulus(input bit rstIn, input logic [3:0] rv, input bit arr,
                                 input bit rval, input logic [3:0] rsr, input logic [1:0] rresp);
        logic [3:0] expReqReady;
        logic [3:0] expRspValid;
        logic [3:0] tmp;
        bit         expRready;
        bit         expErr;
        bit         grant;
        bit         doPop;
        bit         arHs;
        int         winner;
        int         lane;
        @(negedge clk);
        rst           = rstIn;
        req_valid     = rv;
        req_offset    = tbOff;
        m_axi_arready = arr;
        m_axi_rvalid  = rval;
        m_axi_rdata   = tbRdata;
        m_axi_rresp   = rresp;
        m_axi_rlast   = 1'b1;
        m_axi_rid     = 1'b0;
        rsp_ready     = rsr;
        #1;
        grant  = 1'b0;
        winner = 0;
        if ((!mArv || arr) && (mQ.size() + int'(mArv) < MAXO) && (rv != 4'b0)) begin
            for (int k = 0; k < N; k++) begin
                lane = (mRr + k) % N;
                tmp  = rv >> lane;
                if (!grant && tmp[0]) begin
                    grant  = 1'b1;
                    winner = lane;
                end
            end
        end
        expReqReady = grant ? (4'b0001 << winner) : 4'b0000;
        expRspValid = 4'b0000;
        expErr      = 1'b0;
        if (mQ.size() > 0) begin
            expRspValid = rval ? (4'b0001 << mQ[0]) : 4'b0000;
            tmp         = rsr >> mQ[0];
            expRready   = tmp[0];
            expErr      = rval && (rresp != 2'b00);
        end else begin
            expRready = rval;
        end
        checkOutput("req_ready", 64'(req_ready), 64'(expReqReady));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(expRspValid));
        checkOutput("rready", 64'(m_axi_rready), 64'(expRready));
        checkOutput("rsp_err", 64'(rsp_err), 64'(expErr));
        checkOutput("arvalid", 64'(m_axi_arvalid), 64'(mArv));
        checkOutput("araddr", 64'(m_axi_araddr), 64'(mAddr));
        checkOutput("protocol_err", 64'(protocol_err), 64'(mProt));
        if (expRspValid != 4'b0000) begin
            checkOutput("rsp_data", rsp_data, tbRdata);
        end
        if (rstIn) begin
            mQ.delete();
            mArv  = 1'b0;
            mAddr = '0;
            mLane = 0;
            mRr   = 0;
            mProt = 1'b0;
        end else begin
            doPop = (mQ.size() > 0) && rval && expRready;
            arHs  = mArv && arr;
            if ((mQ.size() == 0) && rval) begin
                mProt = 1'b1;
            end
            if (doPop) begin
                void'(mQ.pop_front());
            end
            if (arHs) begin
                mQ.push_back(mLane);
            end
            if (grant) begin
                mArv  = 1'b1;
                mAddr = laneAddr(winner);
                mLane = winner;
                mRr   = (winner + 1) % N;
            end else if (arr) begin
                mArv = 1'b0;
            end
        end
    endtask

    task automatic drainAll();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1, mQ.size() > 0 || mArv, 4'b1111, 2'b00);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_offset = '0; rsp_ready = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = '0; m_axi_rlast = 1'b1; m_axi_rid = 1'b0;
        mArv = 1'b0; mAddr = '0; mLane = 0; mRr = 0; mProt = 1'b0;
        tbOff = '0; tbRdata = '0;

        // Reset state and constant AR fields
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        checkOutput("arlen", 64'(m_axi_arlen), 64'd0);
        checkOutput("arsize", 64'(m_axi_arsize), 64'd3);
        checkOutput("arburst", 64'(m_axi_arburst), 64'd1);
        checkOutput("arcache", 64'(m_axi_arcache), 64'd3);

        // Single lane 2 read with offset 0x1C
        tbOff = {32'h0, 32'h0000_001C, 64'h0};
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 4'b1111, 2'b00);
        checkOutput("tp1_req_ready", 64'(req_ready), 64'h4);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 2'b00);
        checkOutput("tp1_araddr", 64'(m_axi_araddr), 64'h4000_0018);
        tbRdata = 64'hAA;
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp1_rsp_valid", 64'(rsp_valid), 64'h4);
        checkOutput("tp1_rsp_data", rsp_data, 64'hAA);

        // Eight back-to-back grants then the outstanding limit
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        tp2Exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 4'b1111, 2'b00);
            checkOutput("tp2_rr_grant", 64'(req_ready), 64'(tp2Exp[i]));
        end
        applyStimulus(1'b0, 4'b0001, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp2_pop_cycle", 64'(req_ready), 64'h0);
        applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0, 4'b1111, 2'b00);
        checkOutput("tp2_after_pop", 64'(req_ready), 64'h1);
        drainAll();

        // AR stall with lane 1 requesting
        tbOff = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 4'b1111, 2'b00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 4'b1111, 2'b00);
            checkOutput("tp3_stall_ready", 64'(req_ready), 64'h0);
            checkOutput("tp3_stall_valid", 64'(m_axi_arvalid), 64'h1);
        end
        drainAll();

        // Issue lanes 3,0,2 and backpressure lane 0
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp4_beat1_lane", 64'(rsp_valid), 64'h8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1110, 2'b00);
            checkOutput("tp4_stall_rready", 64'(m_axi_rready), 64'h0);
        end
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp4_beat2_lane", 64'(rsp_valid), 64'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp4_beat3_lane", 64'(rsp_valid), 64'h4);

        // Stray beat with nothing outstanding
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'b00);
        checkOutput("tp5_stray_rready", 64'(m_axi_rready), 64'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'b00);
        checkOutput("tp5_sticky", 64'(protocol_err), 64'h1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("tp5_cleared", 64'(protocol_err), 64'h0);

        // Error response flagged for one beat only
        applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0011, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b10);
        checkOutput("tp6_err_beat", 64'(rsp_err), 64'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'b00);
        checkOutput("tp6_ok_beat", 64'(rsp_err), 64'h0);

        // Reset while three reads are outstanding
        applyStimulus(1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0111, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'b00);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'b00);
        checkOutput("tp6_rst_arvalid", 64'(m_axi_arvalid), 64'h0);
        checkOutput("tp6_rst_empty", 64'(m_axi_rready), 64'h1);
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'b00);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tbOff   = {$urandom, $urandom, $urandom, $urandom};
            tbRdata = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 299) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          (mQ.size() > 0) && ($urandom_range(0, 2) != 0),
                          4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
